spi_reg_bank: RTL

- Parametrised SPI mode-0 target with a register bank. It replaces the fixed five-register, SCLK-clocked write-only peripheral.
- SPI pins are oversampled in the system clock domain: 2-flop synchronisers feed edge detectors.
- Supports write frames with commit on nCS deassert, address-range rejection, a per-write strobe, and optional read-back on CIPO.
- Sits between the chip pins and the PWM/config logic, which consumes the flattened register outputs.

---
 rtl/spi_reg_pkg.sv | 30 +++
 rtl/spi_sync_edge.sv | 39 +++
 rtl/spi_reg_bank.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_pkg
//  Description : Shared types and constants for the SPI register bank:
//                frame FSM state encoding, R/W bit values and a helper
//                for the total frame length.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    // Frame FSM states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Value of the leading frame bit
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    // Total number of SCLK bits in one complete frame
    function automatic int FRAME_BITS(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_sync_edge
//  Description : Two-flop synchroniser for an asynchronous pin, followed by
//                a third flop used for rise/fall edge detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the pin into the synchroniser chain; bit 2 is the edge-detect flop
    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    // Synchroniser and edge-detect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : spi_reg_bank
//  Description : SPI mode-0 target with a NUM_REGS x DATA_W register bank.
//                SPI pins are oversampled in the clk domain. Write frames
//                commit on nCS deassert; out-of-range and short frames are
//                discarded.
//                Optional read-back on CIPO: SPI_REG_BANK_READBACK_EN
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int                NUM_REGS  = 5,
    parameter int                ADDR_W    = 7,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_valid,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       cipo,
    output logic                       cipo_oe
);

    localparam int                CNT_W      = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
    localparam logic [ADDR_W:0]   NUM_REGS_C = (ADDR_W + 1)'(NUM_REGS);

    // Synchronised pin events
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl,  ncs_rise,  ncs_fall;

    spi_sync_edge u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge u_sync_copi (
        .clk   (clk),
        .rst   (rst),
        .din   (copi),
        .level (copi_lvl),
        .rise  (copi_rise),
        .fall  (copi_fall)
    );

    spi_sync_edge u_sync_ncs (
        .clk   (clk),
        .rst   (rst),
        .din   (ncs),
        .level (ncs_lvl),
        .rise  (ncs_rise),
        .fall  (ncs_fall)
    );

    // Frame state
    state_t              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic                rw_q,       rw_d;
    logic [ADDR_W-1:0]   addr_q,     addr_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
    logic                w_addr_in_range;

`ifdef SPI_REG_BANK_READBACK_EN
    // Read-back shifter: tx_arm_q marks that a data bit was sampled, so the
    // following SCLK fall moves on to the next bit. The fall right after the
    // final address bit must not shift, otherwise the MSB would be lost.
    logic [DATA_W-1:0]   tx_q,       tx_d;
    logic                tx_oe_q,    tx_oe_d;
    logic                tx_arm_q,   tx_arm_d;
    logic [DATA_W-1:0]   rd_src;
`endif

    assign w_addr_in_range = ({1'b0, addr_q} < NUM_REGS_C);

    // Frame decoding, commit and read-back next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        data_d     = data_q;
        regs_d     = regs_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
`ifdef SPI_REG_BANK_READBACK_EN
        tx_d       = tx_q;
        tx_oe_d    = tx_oe_q;
        tx_arm_d   = tx_arm_q;
        rd_src     = '0;
`endif

        if (ncs_rise) begin
            // nCS release ends every frame; a concurrent SCLK edge is dropped
            state_d = ST_IDLE;
            if (state_q == ST_DONE && rw_q == RW_WRITE && w_addr_in_range) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (addr_q == ADDR_W'(i)) begin
                        regs_d[i] = data_q;
                    end
                end
                wr_valid_d = 1'b1;
                wr_addr_d  = addr_q;
            end
`ifdef SPI_REG_BANK_READBACK_EN
            tx_d     = '0;
            tx_oe_d  = 1'b0;
            tx_arm_d = 1'b0;
`endif
        end else if (ncs_fall) begin
            // Start of frame, or restart after a chip-select glitch
            state_d = ST_CMD;
            cnt_d   = '0;
            rw_d    = 1'b0;
            addr_d  = '0;
            data_d  = '0;
`ifdef SPI_REG_BANK_READBACK_EN
            tx_d     = '0;
            tx_oe_d  = 1'b0;
            tx_arm_d = 1'b0;
`endif
        end else if (sclk_rise) begin
            case (state_q)
                ST_CMD: begin
                    rw_d    = copi_lvl;
                    cnt_d   = CNT_W'(ADDR_W - 1);
                    state_d = ST_ADDR;
                end
                ST_ADDR: begin
                    addr_d = (addr_q << 1) | ADDR_W'(copi_lvl);
                    if (cnt_q == '0) begin
                        cnt_d   = CNT_W'(DATA_W - 1);
                        state_d = ST_DATA;
`ifdef SPI_REG_BANK_READBACK_EN
                        if (rw_q == RW_READ) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr_d == ADDR_W'(i)) begin
                                    rd_src = regs_q[i];
                                end
                            end
                            tx_d    = rd_src;
                            tx_oe_d = 1'b1;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rw_q == RW_WRITE) begin
                        data_d = (data_q << 1) | DATA_W'(copi_lvl);
                    end
`ifdef SPI_REG_BANK_READBACK_EN
                    tx_arm_d = tx_oe_q;
`endif
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE ignore SCLK
                end
            endcase
`ifdef SPI_REG_BANK_READBACK_EN
        end else if (sclk_fall && tx_arm_q) begin
            tx_d     = tx_q << 1;
            tx_arm_d = 1'b0;
`endif
        end
    end

    // Frame and register bank state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            regs_q     <= regs_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_out[gi*DATA_W +: DATA_W] = regs_q[gi];
        end
    endgenerate

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;

`ifdef SPI_REG_BANK_READBACK_EN
    // Read-back shifter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q     <= '0;
            tx_oe_q  <= 1'b0;
            tx_arm_q <= 1'b0;
        end else begin
            tx_q     <= tx_d;
            tx_oe_q  <= tx_oe_d;
            tx_arm_q <= tx_arm_d;
        end
    end

    assign cipo    = tx_q[DATA_W-1];
    assign cipo_oe = tx_oe_q;

    logic w_unused;
    assign w_unused = ^{sclk_lvl, copi_rise, copi_fall, ncs_lvl};
`else
    assign cipo    = 1'b0;
    assign cipo_oe = 1'b0;

    logic w_unused;
    assign w_unused = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall, ncs_lvl};
`endif

endmodule
`default_nettype wire
